// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run-control and completion monitor that sits beside the cpu in
// program-level benches. It watches the fetch PC and the data-memory write port and
// ends the run on the first of three events:
//   - a store to TOHOST_ADDR (exit mailbox; the store data becomes the exit code),
//   - a halt self-loop (HALT_REPEAT consecutive identical valid PCs),
//   - a timeout after MAX_CYCLES run cycles.
// Once done, every output is frozen until clear or reset.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous restart: zero counters, return to run
//   pc           in   fetch PC
//   pc_valid     in   fetch advanced this cycle
//   stall        in   pipeline stall/bubble this cycle
//   dmem_we      in   data-memory write enable
//   dmem_addr    in   data-memory write address
//   dmem_wdata   in   data-memory write data
//   done         out  run finished (sticky)
//   pass         out  run passed (valid when done)
//   status       out  00 running, 01 tohost exit, 10 halt loop, 11 timeout
//   exit_code    out  store data captured on tohost exit, else 0
//   cycle_count  out  run cycles elapsed (includes the terminating cycle)
//   instr_count  out  pc_valid cycles while running
//   stall_count  out  stall cycles while running

module cpu_run_monitor #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CNT_W       = 32,
    parameter int unsigned       MAX_CYCLES  = 500,
    parameter int unsigned       HALT_REPEAT = 4,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_FFF0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              stall,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              done,
    output logic              pass,
    output logic [1:0]        status,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int unsigned REP_W = $clog2(HALT_REPEAT) + 1;

    // rep_cnt counts repeats after the first sighting, so the HALT_REPEAT-th identical
    // PC arrives while rep_cnt holds HALT_REPEAT-2.
    localparam logic [REP_W-1:0] RepLast = REP_W'(HALT_REPEAT - 2);
    // The timeout edge is the one that samples cycle_count == MAX_CYCLES-1, which
    // leaves cycle_count == MAX_CYCLES afterwards.
    localparam logic [CNT_W-1:0] CycLast = CNT_W'(MAX_CYCLES - 1);

    localparam logic [1:0] StatusRun     = 2'b00;
    localparam logic [1:0] StatusTohost  = 2'b01;
    localparam logic [1:0] StatusHalt    = 2'b10;
    localparam logic [1:0] StatusTimeout = 2'b11;

    typedef enum logic {StRun, StDone} state_e;

    state_e state_q, state_d;

    logic              pass_q, pass_d;
    logic [1:0]        status_q, status_d;
    logic [DATA_W-1:0] exit_code_q, exit_code_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic              last_valid_q, last_valid_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

    logic running;
    logic pc_match;
    logic tohost_ev;
    logic halt_ev;
    logic timeout_ev;
    logic any_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Event detection (only meaningful while running)
    always_comb begin
        running    = (state_q == StRun);
        // last_valid_q stops the first valid PC after reset/clear matching the reset
        // value of last_pc.
        pc_match   = pc_valid && last_valid_q && (pc == last_pc_q);
        tohost_ev  = running && dmem_we && (dmem_addr == TOHOST_ADDR);
        halt_ev    = running && pc_match && (rep_cnt_q == RepLast);
        timeout_ev = running && (cycle_count_q == CycLast);
        any_ev     = tohost_ev || halt_ev || timeout_ev;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over any event on the same edge
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun:  if (any_ev) state_d = StDone;
                StDone: state_d = StDone;
            endcase
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        pass_d        = pass_q;
        status_d      = status_q;
        exit_code_d   = exit_code_q;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        stall_count_d = stall_count_q;
        last_pc_d     = last_pc_q;
        last_valid_d  = last_valid_q;
        rep_cnt_d     = rep_cnt_q;

        if (clear) begin
            pass_d        = 1'b0;
            status_d      = StatusRun;
            exit_code_d   = '0;
            cycle_count_d = '0;
            instr_count_d = '0;
            stall_count_d = '0;
            last_pc_d     = '0;
            last_valid_d  = 1'b0;
            rep_cnt_d     = '0;
        end else if (running) begin
            // Counters include the terminating cycle.
            cycle_count_d = sat_inc(cycle_count_q);
            if (pc_valid) instr_count_d = sat_inc(instr_count_q);
            if (stall)    stall_count_d = sat_inc(stall_count_q);

            // Invalid fetch cycles leave halt tracking untouched so stalls inside a
            // self-loop do not break it.
            if (pc_valid) begin
                rep_cnt_d    = pc_match ? rep_cnt_q + REP_W'(1) : '0;
                last_pc_d    = pc;
                last_valid_d = 1'b1;
            end

            if (tohost_ev) begin
                status_d    = StatusTohost;
                exit_code_d = dmem_wdata;
                pass_d      = (dmem_wdata == DATA_W'(1));
            end else if (halt_ev) begin
                status_d    = StatusHalt;
                exit_code_d = '0;
                pass_d      = 1'b1;
            end else if (timeout_ev) begin
                status_d    = StatusTimeout;
                exit_code_d = '0;
                pass_d      = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q        <= 1'b0;
            status_q      <= StatusRun;
            exit_code_q   <= '0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
            stall_count_q <= '0;
            last_pc_q     <= '0;
            last_valid_q  <= 1'b0;
            rep_cnt_q     <= '0;
        end else begin
            pass_q        <= pass_d;
            status_q      <= status_d;
            exit_code_q   <= exit_code_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
            last_pc_q     <= last_pc_d;
            last_valid_q  <= last_valid_d;
            rep_cnt_q     <= rep_cnt_d;
        end
    end

    assign done        = (state_q == StDone);
    assign pass        = pass_q;
    assign status      = status_q;
    assign exit_code   = exit_code_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor (MAX_CYCLES=20, HALT_REPEAT=4).
// Expected output snapshots are pushed to a scoreboard queue as each scenario's
// stimulus is planned and popped when the DUT reaches the matching point.
// Snapshot hex layout: {done, pass, status[1:0], exit_code, cycle, instr, stall}.

module tb_cpu_run_monitor;

    localparam int unsigned MaxC = 20;
    localparam int unsigned HRep = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        pc_valid = 1'b0;
    logic        stall = 1'b0;
    logic        dmem_we = 1'b0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic        done;
    logic        pass;
    logic [1:0]  status;
    logic [31:0] exit_code;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [31:0] stall_count;

    cpu_run_monitor #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .CNT_W      (32),
        .MAX_CYCLES (MaxC),
        .HALT_REPEAT(HRep),
        .TOHOST_ADDR(32'h0000_FFF0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .stall      (stall),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .done       (done),
        .pass       (pass),
        .status     (status),
        .exit_code  (exit_code),
        .cycle_count(cycle_count),
        .instr_count(instr_count),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic [1:0]  status;
        logic [31:0] exit_code;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [31:0] stl;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs;
    snap_t exp_s;
    int    total = 0;
    int    bad = 0;

    function automatic snap_t observe();
        return {done, pass, status, exit_code, cycle_count, instr_count, stall_count};
    endfunction

    function automatic void push_exp(input logic d, input logic p, input logic [1:0] s,
                                     input logic [31:0] e, input logic [31:0] c,
                                     input logic [31:0] i, input logic [31:0] st);
        exp_q.push_back({d, p, s, e, c, i, st});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_valid   = 1'b0;
        stall      = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // n edges of straight-line fetch; optional tohost store on the last edge.
    task automatic drive_prog(input int n, input bit store, input logic [31:0] data);
        for (int i = 0; i < n; i++) begin
            pc_valid = 1'b1;
            pc       = pc + 32'd4;
            if (store && i == n - 1) begin
                dmem_we    = 1'b1;
                dmem_addr  = 32'h0000_FFF0;
                dmem_wdata = data;
            end
            tick();
            idle_inputs();
        end
    endtask

    task automatic fetch(input logic v, input logic [31:0] a, input logic st);
        pc_valid = v;
        pc       = a;
        stall    = st;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        push_exp(0, 0, 2'b00, 0, 0, 0, 0);
        #12;
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL reset_values: got=%h want=%h", obs, exp_s);
        end
        // clear and a tohost store are both ignored while held in reset
        push_exp(0, 0, 2'b00, 0, 0, 0, 0);
        clear = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h0000_FFF0; dmem_wdata = 32'd1;
        pc_valid = 1'b1;
        tick(); tick();
        clear = 1'b0; idle_inputs();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL reset_hold: got=%h want=%h", obs, exp_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tohost_pass();
        push_exp(1, 1, 2'b01, 1, 10, 10, 0);
        drive_prog(9, 0, 0);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL tohost_early_done: got=%b want=0", done);
        end
        drive_prog(1, 1, 32'd1);
        for (int k = 0; k < 5 && done !== 1'b1; k++) tick();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL tohost_pass: got=%h want=%h", obs, exp_s);
        end
    endtask

    task automatic test_tohost_fail();
        push_exp(0, 0, 2'b00, 0, 0, 0, 0);
        do_clear();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL clear_from_done: got=%h want=%h", obs, exp_s);
        end
        push_exp(1, 0, 2'b01, 5, 10, 10, 0);
        push_exp(1, 0, 2'b01, 5, 10, 10, 0);
        drive_prog(9, 0, 0);
        drive_prog(1, 1, 32'd5);
        for (int k = 0; k < 5 && done !== 1'b1; k++) tick();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL tohost_fail: got=%h want=%h", obs, exp_s);
        end
        drive_prog(3, 1, 32'd1);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL done_frozen: got=%h want=%h", obs, exp_s);
        end
    endtask

    task automatic test_halt();
        do_clear();
        push_exp(1, 1, 2'b10, 0, 7, 4, 3);
        fetch(1, 32'h40, 0); fetch(0, 32'h44, 1);
        fetch(1, 32'h40, 0); fetch(0, 32'h44, 1);
        fetch(1, 32'h40, 0); fetch(0, 32'h44, 1);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL halt_early_done: got=%b want=0", done);
        end
        fetch(1, 32'h40, 0);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL halt_with_stalls: got=%h want=%h", obs, exp_s);
        end
        // a different PC in between restarts the repeat count
        do_clear();
        push_exp(0, 0, 2'b00, 0, 4, 4, 0);
        push_exp(1, 1, 2'b10, 0, 7, 7, 0);
        fetch(1, 32'h40, 0); fetch(1, 32'h40, 0); fetch(1, 32'h44, 0); fetch(1, 32'h40, 0);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL halt_broken_loop: got=%h want=%h", obs, exp_s);
        end
        fetch(1, 32'h40, 0); fetch(1, 32'h40, 0); fetch(1, 32'h40, 0);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL halt_after_restart: got=%h want=%h", obs, exp_s);
        end
    endtask

    task automatic test_timeout();
        do_clear();
        push_exp(1, 0, 2'b11, 0, MaxC, 0, 0);
        for (int i = 1; i < MaxC; i++) tick();
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL timeout_early_done: got=%b want=0", done);
        end
        tick();
        for (int k = 0; k < 5 && done !== 1'b1; k++) tick();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL timeout: got=%h want=%h", obs, exp_s);
        end
    endtask

    task automatic test_priority();
        do_clear();
        push_exp(1, 1, 2'b01, 1, MaxC, 0, 0);
        for (int i = 1; i < MaxC; i++) tick();
        dmem_we = 1'b1; dmem_addr = 32'h0000_FFF0; dmem_wdata = 32'd1;
        tick();
        idle_inputs();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL tohost_over_timeout: got=%h want=%h", obs, exp_s);
        end
        // tohost also beats a halt landing on the same edge
        do_clear();
        push_exp(1, 0, 2'b01, 7, 4, 4, 0);
        fetch(1, 32'h80, 0); fetch(1, 32'h80, 0); fetch(1, 32'h80, 0);
        dmem_we = 1'b1; dmem_addr = 32'h0000_FFF0; dmem_wdata = 32'd7;
        fetch(1, 32'h80, 0);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL tohost_over_halt: got=%h want=%h", obs, exp_s);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        push_exp(0, 0, 2'b00, 0, 7, 7, 0);
        push_exp(0, 0, 2'b00, 0, 0, 0, 0);
        push_exp(0, 0, 2'b00, 0, 1, 1, 0);
        drive_prog(7, 0, 0);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL count_before_reset: got=%h want=%h", obs, exp_s);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL async_reset: got=%h want=%h", obs, exp_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_prog(1, 0, 0);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL resume_after_reset: got=%h want=%h", obs, exp_s);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        push_exp(1, 1, 2'b01, 1, 10, 10, 0);
        push_exp(0, 0, 2'b00, 0, 0, 0, 0);
        push_exp(1, 1, 2'b01, 1, 10, 10, 0);
        drive_prog(10, 1, 32'd1);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL run_one: got=%h want=%h", obs, exp_s);
        end
        do_clear();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL clear_between_runs: got=%h want=%h", obs, exp_s);
        end
        drive_prog(10, 1, 32'd1);
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL run_two: got=%h want=%h", obs, exp_s);
        end
        // clear on the same edge as a tohost store: the event is lost
        do_clear();
        push_exp(0, 0, 2'b00, 0, 0, 0, 0);
        push_exp(0, 0, 2'b00, 0, 1, 0, 0);
        clear = 1'b1; pc_valid = 1'b1; pc = pc + 32'd4;
        dmem_we = 1'b1; dmem_addr = 32'h0000_FFF0; dmem_wdata = 32'd1;
        tick();
        clear = 1'b0; idle_inputs();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL clear_beats_event: got=%h want=%h", obs, exp_s);
        end
        tick();
        exp_s = exp_q.pop_front(); obs = observe(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL run_after_clear: got=%h want=%h", obs, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_tohost_pass();
        test_tohost_fail();
        test_halt();
        test_timeout();
        test_priority();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Parametrised run-control and completion monitor that sits beside the `cpu` in every program-level bench. It replaces the fixed-time run-and-finish pattern with observed end-of-program detection. It watches the fetch PC and data-memory write port, and detects three completion conditions: a store to the exit address, a halt self-loop, or a cycle timeout. It reports pass/fail, an exit code and performance counters. The bench calls `$finish` on `done`, so one bench module serves every `.dat` program.

## Interface
Parameters:
- ADDR_W, 32, PC and data-address width
- DATA_W, 32, store-data width
- CNT_W, 32, counter width
- MAX_CYCLES, 500, timeout in RUN cycles (≥2)
- HALT_REPEAT, 4, consecutive identical valid PCs that mean halt (≥2)
- TOHOST_ADDR, 32'h0000_FFF0, exit-mailbox data address

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart: zero counters, return to RUN
- pc  in  ADDR_W  fetch PC
- pc_valid  in  1  fetch advanced this cycle (not stalled)
- stall  in  1  pipeline stall/bubble inserted this cycle
- dmem_we  in  1  data-memory write enable
- dmem_addr  in  ADDR_W  data-memory write address
- dmem_wdata  in  DATA_W  data-memory write data
- done  out  1  run finished (sticky)
- pass  out  1  run passed (valid when done)
- status  out  2  00 running, 01 tohost exit, 10 halt loop, 11 timeout
- exit_code  out  DATA_W  store data captured on tohost exit, else 0
- cycle_count  out  CNT_W  RUN cycles elapsed
- instr_count  out  CNT_W  pc_valid cycles in RUN
- stall_count  out  CNT_W  stall cycles in RUN

## Operation
- States: RUN, DONE. Reset and clear both enter RUN. DONE holds until clear or reset.
- Reset values: done=0, pass=0, status=00, exit_code=0, all counters 0. The internal last_pc register is 0 and rep_cnt is 0.
- In RUN, every edge:
  - cycle_count+1.
  - instr_count+1 if pc_valid.
  - stall_count+1 if stall.
  - All counters saturate at all-ones.
- Halt detect:
  - On a pc_valid cycle, if pc==last_pc then rep_cnt+1, else rep_cnt=0. last_pc then takes pc.
  - Cycles with pc_valid=0 leave rep_cnt and last_pc unchanged, so stalls do not break a loop.
  - Halt event fires when a pc_valid cycle has pc==last_pc and rep_cnt==HALT_REPEAT-2, i.e. the HALT_REPEAT-th identical PC.
  - The first pc_valid after reset/clear never matches; last_pc is treated as invalid until then.
- Tohost event: dmem_we && dmem_addr==TOHOST_ADDR in RUN.
- Timeout event: cycle_count==MAX_CYCLES-1 in RUN.
- Event priority on the same cycle: tohost > halt > timeout.
- On an event, transition to DONE and set done=1 with the following outputs:
  - tohost: status=01, exit_code=dmem_wdata, pass=(dmem_wdata==1).
  - halt: status=10, pass=1, exit_code=0.
  - timeout: status=11, pass=0.
- In DONE, counters, outputs and halt tracking are frozen, and further stores/PCs are ignored.
- clear has priority over every event and over reset-free state. It is ignored while rst_n=0.

## Timing
- All outputs are registered. done/status/pass/exit_code are updated at the same rising edge that samples the event, so there is zero added latency and the bench sees them in the following cycle.
- Counters include the terminating cycle. A timeout leaves cycle_count==MAX_CYCLES.
- Asserting rst_n low mid-run clears everything immediately (asynchronous). Counting resumes on the first rising edge after deassertion.
- A clear asserted on the same edge as an event yields RUN with zeroed counters. The event is lost.

## Test plan
- Defaults, pc_valid=1 with incrementing pc, and a store of 1 to 0xFFF0 sampled at edge 10 -> done=1, status=01, pass=1, exit_code=1, cycle_count=10, instr_count=10.
- Same sequence storing 5 to 0xFFF0 -> status=01, pass=0, exit_code=5. A later store of 1 does not change any output.
- HALT_REPEAT=4, pc=0x40 on four pc_valid cycles interleaved with three stall cycles (pc_valid=0, stall=1) -> done on the 4th valid 0x40, status=10, pass=1, stall_count=3. The sequence 0x40,0x40,0x44,0x40 gives no halt.
- MAX_CYCLES=20, no events -> done at edge 20, status=11, pass=0, cycle_count=20.
- MAX_CYCLES=20 with a tohost write of 1 on edge 20 -> status=01, pass=1 (priority over timeout).
- Mid-run rst_n pulse at cycle 7 -> all outputs 0 asynchronously. In DONE, a clear pulse -> status=00, counters 0, and a rerun reproduces the first scenario exactly.
